// File: rtl/cnv_window_gen.sv
// Raster pixel stream to zero-padded 3x3 neighbourhood generator feeding the mac array.
// Two line buffers plus a shifting 3x3 register window; padding is applied from centre counters.
module cnv_window_gen #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         vld_i,
    input  logic [7:0]   pix_i,
    output logic         rdy_o,
    output logic [127:0] din_o,
    output logic         vld_o,
    output logic         done_o
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]        in_col, c_col;
    logic [RW-1:0]        in_row, c_row;
    logic [7:0]           lb0 [WIDTH];
    logic [7:0]           lb1 [WIDTH];
    logic [2:0][2:0][7:0] win, win_nxt;
    logic [127:0]         din_nxt;
    logic                 acc, step, emit, in_last, c_last, fill_end;

    assign acc      = vld_i && rdy_o;
    assign step     = acc || (state == FLUSH);
    assign in_last  = (in_col == COL_LAST);
    assign c_last   = (c_row == ROW_LAST) && (c_col == COL_LAST);
    assign fill_end = (in_row == RW'(1)) && (in_col == CW'(1));
    assign emit     = (state == FLUSH) || (acc && (state == RUN || (state == FILL && fill_end)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = FILL;
            FILL:    if (acc && fill_end) state_nxt = RUN;
            RUN:     if (acc && in_row == ROW_LAST && in_last) state_nxt = FLUSH;
            FLUSH:   if (c_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // New right-hand column: two rows from the line buffers, newest row from the input.
    // Stale buffer contents at frame start and wrapped columns are removed by masking below.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nxt[i][0] = win[i][1];
            win_nxt[i][1] = win[i][2];
        end
        win_nxt[0][2] = lb1[in_col];
        win_nxt[1][2] = lb0[in_col];
        win_nxt[2][2] = (state == FLUSH) ? 8'h00 : pix_i;
    end

    always_comb begin
        din_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (!((i == 0 && c_row == '0) || (i == 2 && c_row == ROW_LAST) ||
                      (j == 0 && c_col == '0) || (j == 2 && c_col == COL_LAST)))
                    din_nxt[8*(3*i+j) +: 8] = win_nxt[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb1[in_col] <= lb0[in_col];
            lb0[in_col] <= pix_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_col <= '0;
            in_row <= '0;
            c_col  <= '0;
            c_row  <= '0;
            win    <= '0;
            din_o  <= '0;
            vld_o  <= 1'b0;
            done_o <= 1'b0;
            rdy_o  <= 1'b0;
        end else begin
            rdy_o  <= (state_nxt != FLUSH);
            vld_o  <= emit;
            done_o <= emit && c_last;
            if (step) begin
                win <= win_nxt;
                if (in_last) begin
                    in_col <= '0;
                    in_row <= in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end
            if (emit) begin
                din_o <= din_nxt;
                if (c_col == COL_LAST) begin
                    c_col <= '0;
                    c_row <= c_last ? '0 : c_row + RW'(1);
                end else begin
                    c_col <= c_col + CW'(1);
                end
            end
            // Flush runs the input counters past the frame; rewind them for the next frame.
            if (state == FLUSH && c_last) begin
                in_col <= '0;
                in_row <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cnv_window_gen.sv
// Self-checking bench for cnv_window_gen on a 4x4 frame: directed frames, gaps, reset, random frames.
module tb_cnv_window_gen;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         vld_i = 1'b0;
    logic [7:0]   pix_i = 8'h00;
    logic         rdy_o, vld_o, done_o;
    logic [127:0] din_o;

    int           ntests = 0;
    int           nfail = 0;
    int           nwin = 0;
    logic [7:0]   frm [N];
    logic [127:0] got [N];

    cnv_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .pix_i(pix_i),
        .rdy_o(rdy_o), .din_o(din_o), .vld_o(vld_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Reference: neighbourhood of centre k read straight from the frame array.
    function automatic logic [127:0] exp_win(input int k);
        logic [127:0] w;
        int r, c;
        w = '0;
        r = k / W;
        c = k % W;
        for (int m = -1; m <= 1; m++)
            for (int n = -1; n <= 1; n++)
                if (r + m >= 0 && r + m < H && c + n >= 0 && c + n < W)
                    w[8*(3*(m+1)+(n+1)) +: 8] = frm[(r+m)*W + c + n];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] p, output logic acc);
        vld_i = v;
        pix_i = p;
        acc   = v && rdy_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input logic exp_v, input logic exp_done);
        chk("vld_o", 128'(vld_o), 128'(exp_v));
        chk("done_o", 128'(done_o), 128'(exp_done));
        if (exp_v && nwin < N) begin
            chk($sformatf("window%0d", nwin), din_o, exp_win(nwin));
            got[nwin] = din_o;
            nwin++;
        end else if (!exp_v && nwin > 0) begin
            chk("din_hold", din_o, exp_win(nwin - 1));
        end
    endtask

    // mode 0: contiguous, 1: vld_i toggling 1,0,1,0, 2: random gaps
    task automatic feed(input int npix, input int mode);
        int   cnt;
        int   budget;
        logic v, acc;
        cnt = 0;
        budget = 0;
        while (cnt < npix && budget < 40 * N) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : ($urandom_range(3) != 0);
            cycle(v, v ? frm[cnt] : 8'($urandom), acc);
            if (acc) cnt++;
            check_out(acc && cnt >= W + 2, 1'b0);
            budget++;
        end
        chk("feed_count", 128'(cnt), 128'(npix));
    endtask

    task automatic flush_chk();
        logic acc;
        for (int i = 0; i <= W; i++) begin
            chk("rdy_flush", 128'(rdy_o), 128'(0));
            cycle(1'($urandom_range(1)), 8'($urandom), acc);
            check_out(1'b1, i == W);
        end
        vld_i = 1'b0;
        chk("rdy_after_flush", 128'(rdy_o), 128'(1));
        chk("win_count", 128'(nwin), 128'(N));
    endtask

    task automatic set_ramp(input int base);
        for (int i = 0; i < N; i++) frm[i] = 8'(base + i);
        nwin = 0;
    endtask

    task automatic check_ramp_consts();
        chk("first_win", 128'(got[0][71:0]), 128'(72'h06_05_00_02_01_00_00_00_00));
        chk("centre_1_1", 128'(got[5][71:0]), 128'(72'h0B_0A_09_07_06_05_03_02_01));
        chk("last_win", 128'(got[N-1][71:0]), 128'(72'h00_00_00_00_10_0F_00_0C_0B));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_din", din_o, '0);
        chk("rst_vld", 128'(vld_o), 128'(0));
        chk("rst_done", 128'(done_o), 128'(0));
        chk("rst_rdy", 128'(rdy_o), 128'(0));
        rstn = 1'b1;

        // contiguous 1..16
        set_ramp(1);
        feed(N, 0);
        flush_chk();
        check_ramp_consts();

        // same frame with vld_i toggling, back-to-back with the previous one
        set_ramp(1);
        feed(N, 1);
        flush_chk();
        check_ramp_consts();

        // back-to-back 17..32: no stale data from the previous frame
        set_ramp(17);
        feed(N, 0);
        flush_chk();
        chk("frame2_first", 128'(got[0][71:0]), 128'(72'h16_15_00_12_11_00_00_00_00));

        // reset after pixel 9, then a full restarted frame
        set_ramp(1);
        feed(9, 0);
        vld_i = 1'b0;
        rstn  = 1'b0;
        #1;
        chk("midrst_din", din_o, '0);
        chk("midrst_vld", 128'(vld_o), 128'(0));
        chk("midrst_rdy", 128'(rdy_o), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        nwin = 0;
        feed(N, 0);
        flush_chk();
        check_ramp_consts();

        // random frames with random gaps
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) frm[i] = 8'($urandom);
            nwin = 0;
            feed(N, 2);
            flush_chk();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
